// File: rtl/otter_pkg.sv
// Shared fetch-side types and constants for the otter core front end.
package otter_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; head word is shown combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop & ~empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  assign head_data = mem[rd_ptr];

  // Pointers are power-of-two wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok && !(RST || flush)) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one-cycle-latency reads ahead of decode and buffers {IR,PC}.
// Decode handshake: an entry transfers when FE_VALID && DE_READY; FE_* hold while FE_VALID && !DE_READY.
module ifetch_queue
  import otter_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        DE_READY,
  output logic        FE_VALID,
  output logic [31:0] FE_IR,
  output logic [31:0] FE_PC,
  output logic [31:0] FE_NEXT_PC,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_RD,
  input  logic [31:0] IMEM_DOUT
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   issued_pc;
  logic          inflight;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign FE_VALID = ~fifo_empty;
  assign pop      = FE_VALID & DE_READY;
  assign push     = inflight & ~REDIRECT;

  // Credit check counts the read already in flight and frees the slot being popped now.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue     = ~RST & ~REDIRECT & (occupancy < DEPTH_W);

  assign IMEM_RD   = issue;
  assign IMEM_ADDR = fetch_pc;

  assign push_entry = '{ir: IMEM_DOUT, pc: issued_pc};

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc  <= RESET_VEC;
      issued_pc <= RESET_VEC;
      inflight  <= 1'b0;
    end else if (REDIRECT) begin
      fetch_pc <= REDIRECT_PC;
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc  <= fetch_pc + 32'd4;
      issued_pc <= fetch_pc;
      inflight  <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (REDIRECT),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop & ~REDIRECT),
    .head_data (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Empty queue presents a harmless NOP at address 0 instead of stale storage.
  always_comb begin
    FE_IR = NOP_INSTR;
    FE_PC = 32'h0000_0000;
    if (FE_VALID) begin
      FE_IR = head.ir;
      FE_PC = head.pc;
    end
  end

  assign FE_NEXT_PC = FE_PC + 32'd4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised and directed bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        de_ready = 1'b0;
  logic        fe_valid;
  logic [31:0] fe_ir, fe_pc, fe_next_pc;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_dout = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  // Expected queue contents, each word {ir, pc}.
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_issued;
  bit          m_inflight;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH     (DEPTH),
    .RESET_VEC (RESET_VEC)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .DE_READY    (de_ready),
    .FE_VALID    (fe_valid),
    .FE_IR       (fe_ir),
    .FE_PC       (fe_pc),
    .FE_NEXT_PC  (fe_next_pc),
    .IMEM_ADDR   (imem_addr),
    .IMEM_RD     (imem_rd),
    .IMEM_DOUT   (imem_dout)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Synchronous instruction memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_dout <= mem_word(imem_addr);
  end

  function automatic bit model_issue();
    int occ;
    occ = exp_q.size() + int'(m_inflight) - int'(exp_q.size() != 0 && de_ready);
    return !rst && !redirect && (occ < int'(DEPTH));
  endfunction

  // Reference model: advances on every rising edge from the current inputs.
  always @(posedge clk) begin
    bit iss;
    started <= 1'b1;
    iss = model_issue();
    if (rst) begin
      exp_q.delete();
      m_inflight = 1'b0;
      m_fpc      = RESET_VEC;
      m_issued   = RESET_VEC;
    end else if (redirect) begin
      exp_q.delete();
      m_inflight = 1'b0;
      m_fpc      = redirect_pc;
    end else begin
      if (exp_q.size() != 0 && de_ready) void'(exp_q.pop_front());
      if (m_inflight) exp_q.push_back({mem_word(m_issued), m_issued});
      if (iss) begin
        m_issued   = m_fpc;
        m_fpc      = m_fpc + 32'd4;
        m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard head mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      check("fe_valid", {31'b0, fe_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("fe_pc", fe_pc, exp_q[0][31:0]);
        check("fe_ir", fe_ir, exp_q[0][63:32]);
        check("fe_next_pc", fe_next_pc, exp_q[0][31:0] + 32'd4);
      end else begin
        check("fe_ir_idle", fe_ir, NOP);
        check("fe_pc_idle", fe_pc, 32'h0);
      end
      check("imem_rd", {31'b0, imem_rd}, {31'b0, model_issue()});
      check("imem_addr", imem_addr, m_fpc);
    end
  end

  task automatic drive(input bit r, input bit rd, input logic [31:0] rpc, input bit dr);
    @(posedge clk);
    #1;
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    de_ready    = dr;
  endtask

  task automatic run(input int n, input bit dr);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, dr);
  endtask

  initial begin
    // Reset then free-running stream.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    run(20, 1'b1);

    // Stall from reset: queue fills, fetch stops, then drains contiguously.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    run(10, 1'b0);
    run(12, 1'b1);

    // Redirect with three entries queued and a read in flight.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    run(4, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    run(8, 1'b1);

    // Redirect coinciding with a pop, then back-to-back redirects.
    drive(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    run(3, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    run(8, 1'b1);

    // Address wrap at the top of memory.
    drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    run(8, 1'b1);

    // One-cycle reset mid-stream.
    run(3, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    run(8, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, rd, dr;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      dr  = ($urandom_range(0, 3) != 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      drive(r, rd, rpc, dr);
    end

    run(4, 1'b1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
